// File: rtl/mu0_boot_memory_if.sv
// Signal bundle between the MU0 boot memory and its environment: program
// load stream, CPU reset/run handshake and the zero-delay CPU bus.
interface mu0_boot_memory_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16
);
  logic                  load_valid;
  logic                  load_ready;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;
  logic                  cpu_rst;
  logic                  cpu_running;
  logic [ADDR_WIDTH-1:0] address;
  logic                  write;
  logic                  read;
  logic [DATA_WIDTH-1:0] writedata;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  done;
  logic [31:0]           cycles;
  logic                  bus_error;

  modport master (
    output load_valid, load_data, load_last, cpu_running,
           address, write, read, writedata,
    input  load_ready, cpu_rst, readdata, done, cycles, bus_error
  );

  modport slave (
    input  load_valid, load_data, load_last, cpu_running,
           address, write, read, writedata,
    output load_ready, cpu_rst, readdata, done, cycles, bus_error
  );
endinterface

// File: rtl/mu0_boot_memory.sv
// Program memory and boot controller for the MU0 CPU: loads an image over a
// valid/ready stream, releases the CPU, then counts run cycles until it halts.
module mu0_boot_memory #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 16,
  parameter int MEM_WORDS  = 4096
) (
  input  logic             clk,
  input  logic             rst,
  mu0_boot_memory_if.slave mem_if
);
  // state | meaning
  // LOAD  | accepting image words, CPU held in reset, bus ignored
  // BOOT  | one cycle after the final word, CPU still in reset
  // RUN   | CPU released, bus served, run cycles counted
  // DONE  | CPU halted, count frozen, bus still served
  typedef enum logic [1:0] {S_LOAD, S_BOOT, S_RUN, S_DONE} state_t;

  localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX    = IDX_W'(MEM_WORDS - 1);
  localparam logic [ADDR_WIDTH:0] WORDS_LIMIT = (ADDR_WIDTH + 1)'(MEM_WORDS);

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      load_ptr_q, load_ptr_d;
  logic [31:0]           cycles_q, cycles_d;
  logic                  done_q, done_d;
  logic                  bus_error_q, bus_error_d;
  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic                  load_ready;
  logic                  load_accept;
  logic                  bus_active;
  logic                  in_range;
  logic [IDX_W-1:0]      bus_idx;

  assign load_ready  = !rst && (state_q == S_LOAD);
  assign load_accept = load_ready && mem_if.load_valid;
  assign bus_active  = !rst && ((state_q == S_RUN) || (state_q == S_DONE));
  assign in_range    = {1'b0, mem_if.address} < WORDS_LIMIT;
  assign bus_idx     = mem_if.address[IDX_W-1:0];

  // Read is combinational, so a same-cycle write still returns the old word.
  assign mem_if.readdata   = (bus_active && mem_if.read && in_range) ? mem[bus_idx] : '0;
  assign mem_if.load_ready = load_ready;
  assign mem_if.cpu_rst    = rst || (state_q == S_LOAD) || (state_q == S_BOOT);
  assign mem_if.done       = done_q;
  assign mem_if.cycles     = cycles_q;
  assign mem_if.bus_error  = bus_error_q;

  // Memory has no reset so an image survives a controller reset.
  always_ff @(posedge clk) begin
    if (load_accept) begin
      mem[load_ptr_q] <= mem_if.load_data;
    end else if (bus_active && mem_if.write && in_range) begin
      mem[bus_idx] <= mem_if.writedata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;
      load_ptr_q  <= '0;
      cycles_q    <= '0;
      done_q      <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_ptr_q  <= load_ptr_d;
      cycles_q    <= cycles_d;
      done_q      <= done_d;
      bus_error_q <= bus_error_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    load_ptr_d  = load_ptr_q;
    cycles_d    = cycles_q;
    done_d      = done_q;
    bus_error_d = bus_error_q;

    if (bus_active && (mem_if.read || mem_if.write) && !in_range) begin
      bus_error_d = 1'b1;
    end

    case (state_q)
      S_LOAD: begin
        if (load_accept) begin
          load_ptr_d = load_ptr_q + IDX_W'(1);
          if (mem_if.load_last || (load_ptr_q == LAST_IDX)) begin
            state_d = S_BOOT;
          end
        end
      end
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        // The halt-detect cycle is not counted.
        if (!mem_if.cpu_running) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else if (cycles_q != 32'hFFFF_FFFF) begin
          cycles_d = cycles_q + 32'd1;
        end
      end
      S_DONE:  state_d = S_DONE;
      default: state_d = S_LOAD;
    endcase
  end
endmodule

// File: tb/tb_mu0_boot_memory.sv
// Self-checking bench for mu0_boot_memory: a 4096-word and an 8-word instance,
// load tables applied in a loop plus bus/halt/reset sequences checked against a model.
module tb_mu0_boot_memory;
  localparam int AW = 12;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_big;
  logic rst_small;

  always #5 clk = ~clk;

  mu0_boot_memory_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) big_if ();
  mu0_boot_memory_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) small_if ();

  mu0_boot_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(4096)) u_big (
    .clk    (clk),
    .rst    (rst_big),
    .mem_if (big_if)
  );

  mu0_boot_memory #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_WORDS(8)) u_small (
    .clk    (clk),
    .rst    (rst_small),
    .mem_if (small_if)
  );

  typedef struct {
    logic          valid;
    logic [DW-1:0] data;
    logic          last;
    logic          exp_ready;
    logic          exp_cpu_rst;
  } load_vec_t;

  load_vec_t     vecs[$];
  logic [DW-1:0] sb_q[$];
  logic [DW-1:0] model_big   [4096];
  logic [DW-1:0] model_small [8];
  int            ptr_big;
  int            ptr_small;
  int            checks   = 0;
  int            failures = 0;

  function automatic load_vec_t mk(input logic v, input logic [DW-1:0] d, input logic l,
                                   input logic er, input logic ec);
    load_vec_t r;
    r.valid = v; r.data = d; r.last = l; r.exp_ready = er; r.exp_cpu_rst = ec;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // which: 0 load_ready, 1 cpu_rst, 2 readdata, 3 done, 4 cycles, 5 bus_error
  function automatic logic [31:0] get(input bit sel, input int which);
    logic [31:0] r;
    r = '0;
    case (which)
      0: r = 32'(sel ? small_if.load_ready : big_if.load_ready);
      1: r = 32'(sel ? small_if.cpu_rst    : big_if.cpu_rst);
      2: r = 32'(sel ? small_if.readdata   : big_if.readdata);
      3: r = 32'(sel ? small_if.done       : big_if.done);
      4: r = sel ? small_if.cycles : big_if.cycles;
      default: r = 32'(sel ? small_if.bus_error : big_if.bus_error);
    endcase
    return r;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_load(input bit sel, input logic v, input logic [DW-1:0] d, input logic l);
    if (sel) begin
      small_if.load_valid = v; small_if.load_data = d; small_if.load_last = l;
    end else begin
      big_if.load_valid = v; big_if.load_data = d; big_if.load_last = l;
    end
  endtask

  task automatic set_bus(input bit sel, input logic [AW-1:0] a, input logic rd, input logic wr,
                         input logic [DW-1:0] wd);
    if (sel) begin
      small_if.address = a; small_if.read = rd; small_if.write = wr; small_if.writedata = wd;
    end else begin
      big_if.address = a; big_if.read = rd; big_if.write = wr; big_if.writedata = wd;
    end
  endtask

  task automatic set_rst(input bit sel, input logic v);
    if (sel) rst_small = v;
    else     rst_big   = v;
  endtask

  // Entered and left at posedge+1; leaves the block idle in LOAD.
  task automatic do_reset(input bit sel);
    set_rst(sel, 1'b1);
    set_load(sel, 1'b0, '0, 1'b0);
    set_bus(sel, '0, 1'b0, 1'b0, '0);
    #1;
    check("rst_cycle_cpu_rst", get(sel, 1), 32'd1);
    check("rst_cycle_ready", get(sel, 0), 32'd0);
    cycle();
    check("rst_ready", get(sel, 0), 32'd0);
    check("rst_cpu_rst", get(sel, 1), 32'd1);
    check("rst_done", get(sel, 3), 32'd0);
    check("rst_cycles", get(sel, 4), 32'd0);
    check("rst_bus_error", get(sel, 5), 32'd0);
    set_rst(sel, 1'b0);
    set_bus(sel, 12'd3, 1'b1, 1'b1, 16'hFFFF);
    #1;
    check("load_ready", get(sel, 0), 32'd1);
    check("load_bus_ignored", get(sel, 2), 32'd0);
    cycle();
    set_bus(sel, '0, 1'b0, 1'b0, '0);
    if (sel) ptr_small = 0;
    else     ptr_big   = 0;
  endtask

  task automatic apply_vecs(input bit sel, input string tag);
    foreach (vecs[i]) begin
      set_load(sel, vecs[i].valid, vecs[i].data, vecs[i].last);
      #1;
      check({tag, "_ready"}, get(sel, 0), 32'(vecs[i].exp_ready));
      check({tag, "_cpu_rst"}, get(sel, 1), 32'(vecs[i].exp_cpu_rst));
      if (vecs[i].valid && vecs[i].exp_ready) begin
        if (sel) begin model_small[ptr_small] = vecs[i].data; ptr_small++; end
        else     begin model_big[ptr_big]     = vecs[i].data; ptr_big++;   end
      end
      cycle();
    end
    set_load(sel, 1'b0, '0, 1'b0);
    vecs.delete();
  endtask

  task automatic bus_op(input bit sel, input logic [AW-1:0] a, input logic rd, input logic wr,
                        input logic [DW-1:0] wd, input string name);
    int            words;
    logic [DW-1:0] exp;
    words = sel ? 8 : 4096;
    set_bus(sel, a, rd, wr, wd);
    exp = '0;
    if (rd && (int'(a) < words)) exp = sel ? model_small[a[2:0]] : model_big[a];
    sb_q.push_back(exp);
    #1;
    check(name, get(sel, 2), 32'(sb_q.pop_front()));
    if (wr && (int'(a) < words)) begin
      if (sel) model_small[a[2:0]] = wd;
      else     model_big[a]        = wd;
    end
    cycle();
    set_bus(sel, '0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_big = 1'b1;
    rst_small = 1'b1;
    for (int s = 0; s < 2; s++) begin
      set_load(s[0], 1'b0, '0, 1'b0);
      set_bus(s[0], '0, 1'b0, 1'b0, '0);
    end
    big_if.cpu_running   = 1'b1;
    small_if.cpu_running = 1'b1;
    cycle();

    // Basic load: valid held high, last on the third word.
    do_reset(1'b0);
    vecs.push_back(mk(1, 16'h0003, 0, 1, 1));
    vecs.push_back(mk(1, 16'h7000, 0, 1, 1));
    vecs.push_back(mk(1, 16'h1234, 1, 1, 1));
    vecs.push_back(mk(1, 16'hDEAD, 0, 0, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 0));
    apply_vecs(1'b0, "load3");
    bus_op(1'b0, 12'd0, 1, 0, '0, "rd_mem0");
    bus_op(1'b0, 12'd1, 1, 0, '0, "rd_mem1");
    bus_op(1'b0, 12'd2, 1, 0, '0, "rd_mem2");
    bus_op(1'b0, 12'd3, 0, 1, 16'h0BAD, "wr_mem3");
    bus_op(1'b0, 12'd5, 0, 1, 16'h0000, "wr_mem5_zero");
    bus_op(1'b0, 12'd5, 1, 1, 16'h1234, "rw_prewrite");
    bus_op(1'b0, 12'd5, 1, 0, '0, "rd_after_write");

    // Stalled load, then halt after ten running cycles.
    do_reset(1'b0);
    vecs.push_back(mk(1, 16'hAAAA, 0, 1, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 1, 1));
    vecs.push_back(mk(1, 16'hBBBB, 1, 1, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 0));
    apply_vecs(1'b0, "stall");
    bus_op(1'b0, 12'd0, 1, 0, '0, "stall_mem0");
    bus_op(1'b0, 12'd1, 1, 0, '0, "stall_mem1");
    bus_op(1'b0, 12'd2, 1, 0, '0, "stall_mem2_kept");
    bus_op(1'b0, 12'd3, 1, 0, '0, "load_write_dropped");
    repeat (5) cycle();
    check("cycles_before_halt", get(1'b0, 4), 32'd10);
    check("done_before_halt", get(1'b0, 3), 32'd0);
    big_if.cpu_running = 1'b0;
    cycle();
    check("halt_done", get(1'b0, 3), 32'd1);
    check("halt_cycles", get(1'b0, 4), 32'd10);
    repeat (20) cycle();
    check("done_held", get(1'b0, 3), 32'd1);
    check("cycles_frozen", get(1'b0, 4), 32'd10);
    check("done_cpu_rst", get(1'b0, 1), 32'd0);
    bus_op(1'b0, 12'd0, 1, 0, '0, "done_bus_read");
    big_if.cpu_running = 1'b1;

    // Mid-RUN reset with cycles at 7; memory must survive it.
    do_reset(1'b0);
    vecs.push_back(mk(1, 16'h5555, 1, 1, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 0));
    apply_vecs(1'b0, "run7");
    repeat (6) cycle();
    check("cycles_mid_run", get(1'b0, 4), 32'd7);
    do_reset(1'b0);
    vecs.push_back(mk(1, 16'h6666, 1, 1, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 1));
    vecs.push_back(mk(0, 16'h0000, 0, 0, 0));
    apply_vecs(1'b0, "reload");
    for (int a = 0; a < 6; a++) bus_op(1'b0, 12'(a), 1, 0, '0, "retained_mem");

    // 8-word instance: load overflow and out-of-range bus accesses.
    do_reset(1'b1);
    for (int i = 0; i < 10; i++)
      vecs.push_back(mk(1, 16'(16'h0100 + i), 0, (i < 8) ? 1'b1 : 1'b0, (i < 9) ? 1'b1 : 1'b0));
    apply_vecs(1'b1, "ovf");
    check("ovf_ready_low", get(1'b1, 0), 32'd0);
    bus_op(1'b1, 12'd9, 0, 1, 16'hEEEE, "oor_write");
    check("oor_bus_error", get(1'b1, 5), 32'd1);
    bus_op(1'b1, 12'd9, 1, 0, '0, "oor_read_zero");
    bus_op(1'b1, 12'd1, 1, 0, '0, "oor_write_dropped");
    bus_op(1'b1, 12'd7, 1, 0, '0, "small_mem7");
    check("bus_error_sticky", get(1'b1, 5), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
